// File: rtl/mem_arbiter_pkg.sv
// Shared types and width defaults for the unified instruction/data memory arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;
endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive fetch losses; starved_o holds once LIMIT losses accrue.
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic lose_i,
  input  logic clr_i,
  output logic starved_o
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (lose_i && (cnt_q != LIM))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign starved_o = (cnt_q == LIM);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data access, one access in flight, data wins by default.
// Define MEM_ARB_FAIR_EN to let fetch win after STARVE_LIMIT consecutive losses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_pc,
  output logic              stall_pipe
);
  arb_state_e        state_q;
  logic              mem_en_q, mem_we_q, if_valid_q, dm_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_inst_q, dm_rdata_q;

  logic dm_req, idle_grant;
  gnt_e win;

  assign dm_req     = dm_read | dm_write;
  assign idle_grant = (state_q == IDLE) && (dm_req || if_req);

`ifdef MEM_ARB_FAIR_EN
  logic starved;

  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .lose_i   (idle_grant && if_req && (win == GNT_DM)),
    .clr_i    (idle_grant && (win == GNT_IF)),
    .starved_o(starved)
  );

  // A starved fetch takes the slot even with a data request pending.
  assign win = (dm_req && !(if_req && starved)) ? GNT_DM : GNT_IF;
`else
  logic starve_unused;
  assign starve_unused = (STARVE_LIMIT > 0);
  assign win = dm_req ? GNT_DM : GNT_IF;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_inst_q   <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // mem_ack is ignored here, so a stray strobe after reset is harmless.
          if (idle_grant) begin
            mem_en_q <= 1'b1;
            if (win == GNT_DM) begin
              state_q     <= DM_BUSY;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
              mem_we_q    <= dm_write;
            end else begin
              state_q    <= IF_BUSY;
              mem_addr_q <= if_addr;
              mem_we_q   <= 1'b0;
            end
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            if_inst_q  <= mem_rdata;
            if_valid_q <= 1'b1;
            mem_en_q   <= 1'b0;
            state_q    <= IDLE;
          end
        end
        DM_BUSY: begin
          if (mem_ack) begin
            if (!mem_we_q) dm_rdata_q <= mem_rdata;
            dm_valid_q <= 1'b1;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;

  assign stall_pipe = dm_req & ~dm_valid_q;
  assign stall_pc   = stall_pipe | (if_req & ~if_valid_q);
endmodule
